seq_detector_param: RTL and testbench

Parametrised, runtime-programmable Moore serial sequence detector; successor to the fixed 4-bit overlapping detectors.
- Samples one serial bit per valid cycle and compares the last PAT_W bits against a loadable pattern.
- Emits a registered one-cycle match pulse, in overlapping or non-overlapping mode.
- Optionally keeps a saturating match counter.
- Sits directly on a serial data line, feeding control/interrupt logic.

---
 rtl/seqdet_pkg.sv | 18 +
 rtl/seqdet_match_cnt.sv | 43 ++++
 rtl/seq_detector_param.sv | 125 ++++++++++++
 tb/tb_seq_detector_param.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// Optional match counter is enabled by defining SEQDET_COUNT_EN.
package seqdet_pkg;

    typedef enum logic {
        SEQDET_NOVL = 1'b0,
        SEQDET_OVL  = 1'b1
    } seqdet_mode_e;

    localparam int SEQDET_PAT_W_MIN = 32'sd2;
    localparam int SEQDET_PAT_W_MAX = 32'sd32;

    // Width needed to count 0..pat_w valid bits inclusive
    function automatic int seqdet_fill_w(input int pat_w);
        return $clog2(pat_w + 32'sd1);
    endfunction

endpackage

// File: rtl/seqdet_match_cnt.sv
// Saturating match counter; only instantiated when SEQDET_COUNT_EN is defined.
module seqdet_match_cnt
    import seqdet_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: clear wins, then saturating increment
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable Moore serial sequence detector with registered match pulse.
// Define SEQDET_COUNT_EN to add the saturating match_cnt output.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1001,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             ovl,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pattern,
`ifdef SEQDET_COUNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             out
);

    localparam int               FILL_W    = seqdet_fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};

    if ((PAT_W < SEQDET_PAT_W_MIN) || (PAT_W > SEQDET_PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W out of legal range");
    end
    if (CNT_W < 32'sd1) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be at least 1");
    end

    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-1:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic              out_r;

    logic [PAT_W-1:0]  pat_nxt_s;
    logic [PAT_W-1:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;
    logic              out_nxt_s;

    logic [PAT_W-1:0]  hist_shift_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic              match_s;
    logic              hit_s;
    seqdet_mode_e      mode_s;

    assign mode_s       = seqdet_mode_e'(ovl);
    assign hist_shift_s = {hist_r[PAT_W-2:0], in};

    // Candidate fill count and match for the bit on the line this cycle
    always_comb begin
        fill_inc_s = fill_r;
        if (fill_r == FILL_FULL) begin
            fill_inc_s = FILL_FULL;
        end else begin
            fill_inc_s = fill_r + FILL_ONE;
        end
        // The fill gate keeps stale history zeros from matching an all-zero pattern
        match_s = (fill_inc_s == FILL_FULL) && (hist_shift_s == pat_r);
    end

    assign hit_s = in_valid && !pat_load && match_s;

    // Next state: load restarts detection, valid bits shift, idle cycles hold
    always_comb begin
        pat_nxt_s  = pat_r;
        hist_nxt_s = hist_r;
        fill_nxt_s = fill_r;
        out_nxt_s  = 1'b0;
        if (pat_load) begin
            pat_nxt_s  = pattern;
            hist_nxt_s = {PAT_W{1'b0}};
            fill_nxt_s = {FILL_W{1'b0}};
            out_nxt_s  = 1'b0;
        end else if (in_valid) begin
            hist_nxt_s = hist_shift_s;
            out_nxt_s  = match_s;
            case (mode_s)
                SEQDET_OVL:  fill_nxt_s = fill_inc_s;
                SEQDET_NOVL: fill_nxt_s = match_s ? {FILL_W{1'b0}} : fill_inc_s;
                default:     fill_nxt_s = fill_inc_s;
            endcase
        end else begin
            hist_nxt_s = hist_r;
            fill_nxt_s = fill_r;
            out_nxt_s  = 1'b0;
        end
    end

    // Pattern, history, fill and match-pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r  <= PAT_RST;
            hist_r <= {PAT_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
            out_r  <= 1'b0;
        end else begin
            pat_r  <= pat_nxt_s;
            hist_r <= hist_nxt_s;
            fill_r <= fill_nxt_s;
            out_r  <= out_nxt_s;
        end
    end

    assign out = out_r;

`ifdef SEQDET_COUNT_EN
    seqdet_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pat_load),
        .inc (hit_s),
        .cnt (match_cnt)
    );
`else
    logic unused_hit_s;
    assign unused_hit_s = hit_s;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param; counter checks compile in with SEQDET_COUNT_EN.
module tb_seq_detector_param;

    logic       clk;
    logic       rst;
    logic       in_s;
    logic       in_valid_s;
    logic       ovl_s;
    logic       pat_load_s;
    logic [3:0] pattern_s;
    logic       out_s;
`ifdef SEQDET_COUNT_EN
    logic [1:0] match_cnt_s;
`endif

    int   n_cmp;
    int   n_bad;
    logic exp_q[$];

    seq_detector_param #(
        .PAT_W   (4),
        .PAT_RST (4'b1001),
        .CNT_W   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_s),
        .in_valid  (in_valid_s),
        .ovl       (ovl_s),
        .pat_load  (pat_load_s),
        .pattern   (pattern_s),
`ifdef SEQDET_COUNT_EN
        .match_cnt (match_cnt_s),
`endif
        .out       (out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: one expected out value per driven cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic e;
            e = exp_q.pop_front();
            check_val("out", {31'd0, out_s}, {31'd0, e});
        end
    end

    task automatic drive(input logic b, input logic v, input logic ld,
                         input logic [3:0] p, input logic e);
        in_s       = b;
        in_valid_s = v;
        pat_load_s = ld;
        pattern_s  = p;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] p);
        drive(1'b0, 1'b0, 1'b1, p, 1'b0);
    endtask

    task automatic feed(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = 0; i < n; i++) begin
            drive(bits[n-1-i], 1'b1, 1'b0, 4'b0000, exps[n-1-i]);
        end
    endtask

    initial begin
        logic [3:0] gap_bits;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        in_s       = 1'b0;
        in_valid_s = 1'b0;
        ovl_s      = 1'b1;
        pat_load_s = 1'b0;
        pattern_s  = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_out", {31'd0, out_s}, 32'd0);
`ifdef SEQDET_COUNT_EN
        check_val("reset_cnt", {30'd0, match_cnt_s}, 32'd0);
`endif
        rst = 1'b0;

        // Default pattern 1001 straight from reset, overlapping
        feed(16'b100101001, 16'b000100001, 9);
`ifdef SEQDET_COUNT_EN
        check_val("cnt_default", {30'd0, match_cnt_s}, 32'd2);
`endif

        // Overlapping versus non-overlapping
        load(4'b1001);
        feed(16'b1001001, 16'b0001001, 7);
        ovl_s = 1'b0;
        load(4'b1001);
        feed(16'b1001001, 16'b0001000, 7);
        ovl_s = 1'b1;

        // in_valid gaps with junk on the data line
        load(4'b1001);
        gap_bits = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            drive(gap_bits[3-i], 1'b1, 1'b0, 4'b0000, (i == 3) ? 1'b1 : 1'b0);
            for (int g = 0; g < 3; g++) begin
                drive(1'($urandom_range(1, 0)), 1'b0, 1'b0, 4'b0000, 1'b0);
            end
        end

        // New pattern, then a load that coincides with a valid bit
        load(4'b1101);
        feed(16'b1101101, 16'b0001001, 7);
        drive(1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
        feed(16'b101, 16'b000, 3);
`ifdef SEQDET_COUNT_EN
        check_val("cnt_after_load", {30'd0, match_cnt_s}, 32'd0);
`endif

        // All-zero pattern must wait for four real bits
        load(4'b0000);
        feed(16'b00000, 16'b00011, 5);

        // Asynchronous reset while out is high restores the default pattern
        load(4'b0110);
        feed(16'b0110110, 16'b0001001, 7);
        #2 rst = 1'b1;
        #1 check_val("async_rst_out", {31'd0, out_s}, 32'd0);
`ifdef SEQDET_COUNT_EN
        check_val("async_rst_cnt", {30'd0, match_cnt_s}, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        feed(16'b01101001, 16'b00000001, 8);

        // Back-to-back matches and counter saturation
        load(4'b1111);
        feed(16'hFF, 16'b00011111, 8);
`ifdef SEQDET_COUNT_EN
        check_val("cnt_saturate", {30'd0, match_cnt_s}, 32'd3);
`endif
        ovl_s = 1'b0;
        load(4'b1111);
        feed(16'hFF, 16'b00010001, 8);
`ifdef SEQDET_COUNT_EN
        check_val("cnt_novl", {30'd0, match_cnt_s}, 32'd2);
`endif

        in_valid_s = 1'b0;
        @(negedge clk);
        check_val("sb_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
